// File: rtl/dmem_bus_pkg.sv
// Shared constants for the data-memory bus controller: address map, STATUS bits,
// RamMode bits and the load alignment/extension helper.
package dmem_bus_pkg;

    localparam logic [31:0] ADDR_TXDATA = 32'h1000_0000;
    localparam logic [31:0] ADDR_STATUS = 32'h1000_0004;
    localparam logic [31:0] ADDR_RXDATA = 32'h1000_0008;

    localparam int ST_TX_EMPTY = 0;
    localparam int ST_TX_FULL  = 1;
    localparam int ST_RX_FULL  = 2;
    localparam int ST_TX_OVF   = 3;

    // RamMode = {byte, half, word, unsigned}; byte wins over half, neither means word
    localparam int RM_UNSIGNED = 0;
    localparam int RM_WORD     = 1;
    localparam int RM_HALF     = 2;
    localparam int RM_BYTE     = 3;

    function automatic logic [31:0] loadAlign(input logic [31:0] word, input logic [1:0] lane,
                                              input logic isByte, input logic isHalf,
                                              input logic isUns);
        logic [31:0] sh;
        logic [31:0] res;
        sh = word >> {lane, 3'b000};
        if (isByte) begin
            res = isUns ? {24'h000000, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
        end else if (isHalf) begin
            res = isUns ? {16'h0000, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
        end else begin
            res = word;
        end
        return res;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO with valid/ready handshakes; a push into a full FIFO succeeds when a pop
// happens in the same cycle.
module byte_fifo
    import dmem_bus_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rstB,
    input  logic [7:0]               inData,
    input  logic                     inValid,
    output logic                     inReady,
    output logic [7:0]               outData,
    input  logic                     outReady,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [7:0]    mem_r [DEPTH];
    logic [AW-1:0] wrPtr_r;
    logic [AW-1:0] rdPtr_r;
    logic [AW:0]   count_r;
    logic          push_s;
    logic          pop_s;

    assign full    = (count_r == FULL_CNT);
    assign empty   = (count_r == {(AW + 1){1'b0}});
    assign count   = count_r;
    assign inReady = ~full | outReady;
    assign outData = mem_r[rdPtr_r];
    assign push_s  = inValid & inReady;
    assign pop_s   = ~empty & outReady;

    // Storage array, written at the tail
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wrPtr_r] <= inData;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (!rstB) begin
            wrPtr_r <= {AW{1'b0}};
            rdPtr_r <= {AW{1'b0}};
            count_r <= {(AW + 1){1'b0}};
        end else begin
            if (push_s) wrPtr_r <= wrPtr_r + PTR_ONE;
            if (pop_s)  rdPtr_r <= rdPtr_r + PTR_ONE;
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/dmem_bus_ctrl.sv
// Core data-memory bus: word RAM with byte lanes, memory-mapped UART TX/RX/STATUS,
// two-cycle load pipeline and a sticky bus error flag.
module dmem_bus_ctrl
    import dmem_bus_pkg::*;
#(
    parameter int RAM_WORDS = 1024,
    parameter int TXF_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rstB,
    input  logic        clkEn,
    input  logic [31:0] addr,
    input  logic [31:0] dataBusOut,
    input  logic        wrEn,
    input  logic        rdEn,
    input  logic [3:0]  RamMode,
    output logic [31:0] dataBusIn,
    output logic        dataBusInEn,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        bus_err
);

    localparam int RAM_AW = $clog2(RAM_WORDS);
    localparam int CNT_W  = $clog2(TXF_DEPTH) + 1;

    logic [31:0]       ram_r [RAM_WORDS];
    logic [31:0]       ramQ_r;
    logic              isWr_s, isRd_s, isByte_s, isHalf_s, misal_s, err_s;
    logic              inRam_s, isTx_s, isSt_s, isRx_s, txPush_s;
    logic [3:0]        byteEn_s;
    logic [31:0]       wrWord_s, status_s, mmioWord_s;
    logic [RAM_AW-1:0] ramIdx_s;
    logic              txInReady_s, txFull_s, txFifoEmpty_s;
    logic [CNT_W-1:0]  txCount_s;
    logic              txOvf_r, rxFull_r;
    logic [7:0]        rxByte_r;
    logic              rdVld_r, rdErr_r, rdRam_r, byte_r, half_r, uns_r;
    logic [1:0]        lane_r;
    logic [31:0]       mmioQ_r;

    // Request qualification, address decode and store lane steering
    always_comb begin
        isWr_s   = rstB & clkEn & wrEn;
        isRd_s   = rstB & clkEn & rdEn & ~wrEn;
        isByte_s = RamMode[RM_BYTE];
        isHalf_s = ~RamMode[RM_BYTE] & RamMode[RM_HALF];
        misal_s  = (isHalf_s & addr[0]) | (~isByte_s & ~isHalf_s & (addr[1:0] != 2'b00));
        inRam_s  = ((addr >> (RAM_AW + 2)) == 32'd0);
        isTx_s   = (addr == ADDR_TXDATA);
        isSt_s   = (addr == ADDR_STATUS);
        isRx_s   = (addr == ADDR_RXDATA);
        err_s    = misal_s | ~(inRam_s | isTx_s | isSt_s | isRx_s);
        ramIdx_s = addr[RAM_AW+1:2];
        txPush_s = isWr_s & isTx_s & ~misal_s;
        if (isByte_s) begin
            byteEn_s = 4'b0001 << addr[1:0];
            wrWord_s = {4{dataBusOut[7:0]}};
        end else if (isHalf_s) begin
            byteEn_s = addr[1] ? 4'b1100 : 4'b0011;
            wrWord_s = {2{dataBusOut[15:0]}};
        end else begin
            byteEn_s = 4'b1111;
            wrWord_s = dataBusOut;
        end
        status_s = {28'd0, txOvf_r, rxFull_r, txFull_s, (txCount_s == CNT_W'(0))};
        if (isSt_s) begin
            mmioWord_s = status_s;
        end else if (isRx_s & rxFull_r) begin
            mmioWord_s = {24'd0, rxByte_r};
        end else begin
            mmioWord_s = 32'd0;
        end
    end

    // Data RAM: lane-masked writes and registered read, contents survive reset
    always_ff @(posedge clk) begin
        if (isWr_s & inRam_s & ~misal_s) begin
            for (int b = 0; b < 4; b++) begin
                if (byteEn_s[b]) ram_r[ramIdx_s][8*b +: 8] <= wrWord_s[8*b +: 8];
            end
        end
        if (isRd_s) ramQ_r <= ram_r[ramIdx_s];
    end

    // Load pipeline: capture at acceptance, align/extend and strobe one cycle later
    always_ff @(posedge clk) begin
        if (!rstB) begin
            rdVld_r     <= 1'b0;
            rdErr_r     <= 1'b0;
            rdRam_r     <= 1'b0;
            mmioQ_r     <= 32'd0;
            lane_r      <= 2'b00;
            byte_r      <= 1'b0;
            half_r      <= 1'b0;
            uns_r       <= 1'b0;
            dataBusIn   <= 32'd0;
            dataBusInEn <= 1'b0;
        end else begin
            rdVld_r <= isRd_s;
            if (isRd_s) begin
                rdErr_r <= err_s;
                rdRam_r <= inRam_s;
                mmioQ_r <= mmioWord_s;
                lane_r  <= addr[1:0];
                byte_r  <= isByte_s;
                half_r  <= isHalf_s;
                uns_r   <= RamMode[RM_UNSIGNED];
            end
            dataBusInEn <= rdVld_r;
            if (rdVld_r) begin
                dataBusIn <= rdErr_r ? 32'd0
                           : loadAlign(rdRam_r ? ramQ_r : mmioQ_r, lane_r, byte_r, half_r, uns_r);
            end
        end
    end

    // Sticky error, TX overflow flag and the RX holding register
    always_ff @(posedge clk) begin
        if (!rstB) begin
            bus_err  <= 1'b0;
            txOvf_r  <= 1'b0;
            rxFull_r <= 1'b0;
            rxByte_r <= 8'd0;
        end else begin
            bus_err <= bus_err | ((isWr_s | isRd_s) & err_s);
            if (txPush_s & ~txInReady_s) begin
                txOvf_r <= 1'b1;
            end else if (isWr_s & isSt_s & dataBusOut[ST_TX_OVF]) begin
                txOvf_r <= 1'b0;
            end
            // An empty holder accepts a new byte even while an RXDATA load reads it as 0
            if (rx_valid & ~rxFull_r) begin
                rxFull_r <= 1'b1;
                rxByte_r <= rx_data;
            end else if (isRd_s & isRx_s) begin
                rxFull_r <= 1'b0;
            end
        end
    end

    assign rx_ready = ~rxFull_r;
    assign tx_valid = ~txFifoEmpty_s;

    byte_fifo #(.DEPTH(TXF_DEPTH)) uTxFifo (
        .clk      (clk),
        .rstB     (rstB),
        .inData   (dataBusOut[7:0]),
        .inValid  (txPush_s),
        .inReady  (txInReady_s),
        .outData  (tx_data),
        .outReady (tx_ready),
        .full     (txFull_s),
        .empty    (txFifoEmpty_s),
        .count    (txCount_s)
    );

endmodule

// File: tb/tb_dmem_bus_ctrl.sv
// Self-checking bench: directed scenarios plus random traffic against a byte-level
// memory/UART reference model.
module tb_dmem_bus_ctrl;

    localparam int RAM_WORDS = 1024;
    localparam int TXF_DEPTH = 4;
    localparam logic [31:0] A_TX = 32'h1000_0000;
    localparam logic [31:0] A_ST = 32'h1000_0004;
    localparam logic [31:0] A_RX = 32'h1000_0008;
    localparam logic [3:0] M_LB = 4'b1000, M_LBU = 4'b1001, M_LH = 4'b0100;
    localparam logic [3:0] M_LHU = 4'b0101, M_LW = 4'b0010;

    logic        clk, rstB, clkEn, wrEn, rdEn, tx_valid, tx_ready, rx_valid, rx_ready;
    logic        dataBusInEn, bus_err;
    logic [31:0] addr, dataBusOut, dataBusIn;
    logic [3:0]  RamMode;
    logic [7:0]  tx_data, rx_data;

    dmem_bus_ctrl #(.RAM_WORDS(RAM_WORDS), .TXF_DEPTH(TXF_DEPTH)) dut (
        .clk(clk), .rstB(rstB), .clkEn(clkEn), .addr(addr), .dataBusOut(dataBusOut),
        .wrEn(wrEn), .rdEn(rdEn), .RamMode(RamMode), .dataBusIn(dataBusIn),
        .dataBusInEn(dataBusInEn), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .bus_err(bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {int due; logic [31:0] val;} exp_t;

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    logic [7:0]  memM [4*RAM_WORDS];
    logic [7:0]  txq [$];
    logic [7:0]  txSeen [$];
    exp_t        expq [$];
    logic        rxFullM = 1'b0, ovfM = 1'b0, errM = 1'b0;
    logic [7:0]  rxByteM = 8'd0;
    logic [31:0] lastData = 32'd0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int accSize(input logic [3:0] m);
        return m[3] ? 1 : (m[2] ? 2 : 4);
    endfunction

    function automatic logic isRam(input logic [31:0] a);
        return a < 32'(4 * RAM_WORDS);
    endfunction

    function automatic logic accessErr(input logic [31:0] a, input logic [3:0] m);
        logic mapped;
        mapped = isRam(a) || a == A_TX || a == A_ST || a == A_RX;
        return !mapped || (a % accSize(m)) != 0;
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] raw, input logic [3:0] m);
        if (m[3]) return m[0] ? {24'd0, raw[7:0]} : 32'($signed(raw[7:0]));
        if (m[2]) return m[0] ? {16'd0, raw[15:0]} : 32'($signed(raw[15:0]));
        return raw;
    endfunction

    // One clock cycle: advance the model with current inputs, then compare after the edge
    task automatic tick();
        logic wr, rd, pop, rxWasFull, errNow;
        logic [31:0] raw, v;
        int sz, txSizePre;
        if (rstB && tx_valid && tx_ready) txSeen.push_back(tx_data);
        if (!rstB) begin
            txq.delete(); expq.delete();
            rxFullM = 1'b0; ovfM = 1'b0; errM = 1'b0; lastData = 32'd0;
        end else begin
            wr = clkEn && wrEn;
            rd = clkEn && rdEn && !wrEn;
            sz = accSize(RamMode);
            errNow = accessErr(addr, RamMode);
            rxWasFull = rxFullM;
            txSizePre = txq.size();
            pop = (txSizePre > 0) && tx_ready;
            if (pop) void'(txq.pop_front());
            if (wr && !errNow) begin
                if (isRam(addr)) begin
                    for (int i = 0; i < sz; i++) memM[addr + i] = dataBusOut[8*i +: 8];
                end else if (addr == A_TX) begin
                    if (txq.size() < TXF_DEPTH) txq.push_back(dataBusOut[7:0]);
                    else ovfM = 1'b1;
                end else if (addr == A_ST && dataBusOut[3]) begin
                    ovfM = 1'b0;
                end
            end
            if (rd) begin
                raw = 32'd0;
                if (errNow) begin
                    v = 32'd0;
                end else begin
                    if (isRam(addr)) begin
                        for (int i = 0; i < sz; i++) raw[8*i +: 8] = memM[addr + i];
                    end else if (addr == A_ST) begin
                        raw = {28'd0, ovfM, rxWasFull, txSizePre == TXF_DEPTH, txSizePre == 0};
                    end else if (addr == A_RX) begin
                        raw = rxWasFull ? {24'd0, rxByteM} : 32'd0;
                        rxFullM = 1'b0;
                    end
                    v = extend(raw, RamMode);
                end
                expq.push_back('{cyc + 2, v});
            end
            if (rx_valid && !rxWasFull) begin
                rxFullM = 1'b1;
                rxByteM = rx_data;
            end
            if ((wr || rd) && errNow) errM = 1'b1;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (expq.size() > 0 && expq[0].due == cyc) begin
            checkVal("strobe", dataBusInEn, 1);
            checkVal("load_data", dataBusIn, expq[0].val);
            lastData = expq[0].val;
            void'(expq.pop_front());
        end else begin
            checkVal("no_strobe", dataBusInEn, 0);
            checkVal("data_hold", dataBusIn, lastData);
        end
        checkVal("bus_err", bus_err, errM);
        checkVal("rx_ready", rx_ready, !rxFullM);
        checkVal("tx_valid", tx_valid, txq.size() > 0);
        if (txq.size() > 0) checkVal("tx_data", tx_data, txq[0]);
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        addr = a; dataBusOut = d; RamMode = m; wrEn = 1'b1;
        tick();
        wrEn = 1'b0;
    endtask

    task automatic load(input logic [31:0] a, input logic [3:0] m);
        addr = a; RamMode = m; rdEn = 1'b1;
        tick();
        rdEn = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] bnd [5];
        logic [3:0]  modes [5];
        int k, r;
        bnd   = '{32'h2000_0000, 32'h0000_1000, 32'h0000_0FFC, 32'h0000_0FFF, 32'h1000_000C};
        modes = '{M_LB, M_LBU, M_LH, M_LHU, M_LW};
        rstB = 1'b0; clkEn = 1'b1; wrEn = 1'b0; rdEn = 1'b0; addr = 32'd0;
        dataBusOut = 32'd0; RamMode = M_LW; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'd0;
        #1;
        repeat (3) tick();
        checkVal("rst_data", dataBusIn, 32'd0);
        checkVal("rst_err", bus_err, 0);
        rstB = 1'b1;
        for (int i = 0; i < 64; i++) store(32'(i * 4), $urandom, M_LW);
        store(32'h0FFC, $urandom, M_LW);

        // Sign vs zero extension, back-to-back loads
        store(32'h10, 32'hDEADBEEF, M_LW);
        load(32'h13, M_LB);
        load(32'h13, M_LBU);
        checkVal("lb_13", dataBusIn, 32'hFFFFFFDE);
        checkVal("lb_13_en", dataBusInEn, 1);
        tick();
        checkVal("lbu_13", dataBusIn, 32'h000000DE);

        store(32'h20, 32'hCAFEF00D, M_LW);
        store(32'h22, 32'h00001234, M_LH);
        load(32'h20, M_LW);
        tick();
        checkVal("sh_merge", dataBusIn, 32'h1234F00D);

        // TX overflow and drain
        tx_ready = 1'b0;
        for (int i = 1; i <= 5; i++) store(A_TX, 32'(i), M_LW);
        load(A_ST, M_LW);
        tick();
        checkVal("status_ovf", dataBusIn, 32'h0000000A);
        txSeen.delete();
        tx_ready = 1'b1;
        repeat (6) tick();
        tx_ready = 1'b0;
        checkVal("tx_count", txSeen.size(), 4);
        for (int i = 0; i < 4; i++)
            checkVal("tx_order", (i < txSeen.size()) ? 32'(txSeen[i]) : 32'hFFFFFFFF, 32'(i + 1));
        store(A_ST, 32'h8, M_LW);
        load(A_ST, M_LW);
        tick();
        checkVal("status_clr", dataBusIn, 32'h00000001);

        // RX holding register
        rx_data = 8'h41; rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        checkVal("rx_busy", rx_ready, 0);
        load(A_RX, M_LW);
        checkVal("rx_freed", rx_ready, 1);
        tick();
        checkVal("rx_byte", dataBusIn, 32'h00000041);
        load(A_RX, M_LW);
        tick();
        checkVal("rx_empty", dataBusIn, 32'd0);

        // Misaligned and unmapped accesses
        checkVal("err_clear", bus_err, 0);
        load(32'h2, M_LW);
        load(32'h2000_0000, M_LW);
        checkVal("mis_data", dataBusIn, 32'd0);
        checkVal("mis_en", dataBusInEn, 1);
        tick();
        checkVal("unm_en", dataBusInEn, 1);
        repeat (4) tick();
        checkVal("err_sticky", bus_err, 1);

        // Reset one cycle after a load
        load(32'h10, M_LW);
        rstB = 1'b0;
        tick();
        rstB = 1'b1;
        checkVal("rst_mid_err", bus_err, 0);
        checkVal("rst_mid_txv", tx_valid, 0);
        tick();
        checkVal("rst_mid_en", dataBusInEn, 0);
        checkVal("rst_mid_data", dataBusIn, 32'd0);

        // Random traffic
        for (int n = 0; n < 500; n++) begin
            k = $urandom_range(0, 9);
            r = $urandom_range(0, 11);
            clkEn = ($urandom_range(0, 7) != 0);
            wrEn = (k >= 4 && k <= 7);
            rdEn = (k <= 3 || k == 7);
            if (r <= 7) addr = 32'($urandom_range(0, 255));
            else if (r == 8) addr = A_TX;
            else if (r == 9) addr = A_ST;
            else if (r == 10) addr = A_RX;
            else addr = bnd[$urandom_range(0, 4)];
            RamMode = modes[$urandom_range(0, 4)];
            dataBusOut = $urandom;
            tx_ready = 1'($urandom_range(0, 1));
            rx_valid = 1'($urandom_range(0, 1));
            rx_data = 8'($urandom);
            tick();
        end
        wrEn = 1'b0; rdEn = 1'b0; rx_valid = 1'b0; tx_ready = 1'b1;
        repeat (8) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dmem_bus_ctrl.md
DMEM_BUS_CTRL -- requirements
Module: dmem_bus_ctrl

Interface
REQ-001 Parameter RAM_WORDS, default 1024, data RAM depth in 32-bit words (power of two).
REQ-002 Parameter TXF_DEPTH, default 4, UART TX FIFO depth in bytes (power of two).
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rstB  in  1  reset, synchronous, active-low.
REQ-005 clkEn  in  1  core enable; requests are ignored while low.
REQ-006 addr  in  32  byte address from core.
REQ-007 dataBusOut  in  32  store data from core, right-aligned.
REQ-008 wrEn / rdEn  in  1 each  store / load request.
REQ-009 RamMode  in  4  {byte, half, word, unsigned}.
REQ-010 dataBusIn  out  32  load data to core, aligned and extended.
REQ-011 dataBusInEn  out  1  load data valid strobe.
REQ-012 tx_data  out  8; tx_valid  out  1; tx_ready  in  1  UART TX byte stream, valid/ready.
REQ-013 rx_data  in  8; rx_valid  in  1; rx_ready  out  1  UART RX byte stream, valid/ready.
REQ-014 bus_err  out  1  sticky misaligned/unmapped access flag.

Function
REQ-015 Map: RAM 0x0000_0000..4*RAM_WORDS-1; TXDATA 0x1000_0000; STATUS 0x1000_0004; RXDATA 0x1000_0008; all else unmapped.
REQ-016 Request accepted in cycle N when clkEn=1 and (wrEn or rdEn); wrEn has priority if both high, read is dropped.
REQ-017 Store to RAM: byte-lane write at edge ending cycle N; byte lane addr[1:0], half lane addr[1], word all lanes.
REQ-018 Load: dataBusIn valid with dataBusInEn=1 for exactly one cycle N+2; dataBusIn held between strobes.
REQ-019 Load extension: byte/half sign-extended unless unsigned=1, then zero-extended; word unchanged.
REQ-020 Back-to-back loads every cycle supported; one result per cycle, in order.
REQ-021 Misaligned (half with addr[0]=1, word with addr[1:0]!=0) or unmapped: store ignored, load returns 0 with strobe, bus_err set.
REQ-022 Store to TXDATA pushes dataBusOut[7:0] into TX FIFO; if full, byte dropped and STATUS.tx_ovf set.
REQ-023 TX FIFO head drives tx_data; tx_valid = not empty; pop on tx_valid&tx_ready; push and pop same cycle on full FIFO both succeed, count unchanged.
REQ-024 RX: one-byte holding register; rx_ready = holding empty; capture on rx_valid&rx_ready.
REQ-025 Load of RXDATA returns {24'b0, byte} and empties holder at acceptance edge; empty holder returns 0.
REQ-026 STATUS = {28'b0, tx_ovf, rx_full, tx_full, tx_empty}; store to STATUS with bit3=1 clears tx_ovf.
REQ-027 Pointers wrap modulo TXF_DEPTH; count range 0..TXF_DEPTH.

Reset
REQ-028 While rstB=0: dataBusIn=0, dataBusInEn=0, bus_err=0, tx_ovf=0, TX FIFO empty, RX holder empty, read pipeline flushed.
REQ-029 Reset mid-load: no strobe issued for the in-flight load after reset releases.
REQ-030 RAM contents not reset.

Structure
REQ-031 Package dmem_bus_pkg holds address-map constants, STATUS bit indices and RamMode bit indices.
REQ-032 TX FIFO is sub-module byte_fifo (parameterised depth, valid/ready, full/empty/count).

Verification
REQ-033 sw 0xDEADBEEF @0x10, then lb @0x13 and lbu @0x13 -> 0xFFFFFFDE, 0x000000DE, each strobe at N+2.
REQ-034 sh 0x1234 @0x22 then lw @0x20 -> upper half 0x1234, lower half unchanged.
REQ-035 tx_ready=0, 5 stores to TXDATA (TXF_DEPTH=4) -> STATUS=0x0000000A; raise tx_ready -> bytes 1..4 out in order.
REQ-036 rx_valid with 0x41 -> rx_ready drops; lw RXDATA -> 0x41, then rx_ready=1, next RXDATA read 0.
REQ-037 lw @0x2 and load @0x2000_0000 -> data 0, strobe present, bus_err=1 until reset.
REQ-038 rstB=0 one cycle after a load -> no dataBusInEn, all outputs at reset values.
